// File: rtl/fast_msg_assembler_if.sv
// Field-lane input and assembled-message output bundle for fast_msg_assembler.
// The assembler uses the slave modport; the upstream/downstream side uses master.
interface fast_msg_assembler_if #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned BEAT_W     = 64,
  parameter int unsigned MAX_FIELDS = 10,
  parameter int unsigned MSG_ID_W   = 21
);
  localparam int unsigned IDX_W   = $clog2(MAX_FIELDS);
  localparam int unsigned FIELD_W = 1 + MSG_ID_W + IDX_W + BEAT_W;

  logic [FIELD_W-1:0]           in_fields [NUM_LANES];
  logic [NUM_LANES-1:0]         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [MSG_ID_W-1:0]          out_msg_id;
  logic [IDX_W:0]               out_nfields;
  logic [MAX_FIELDS*BEAT_W-1:0] out_data;
  logic                         drop_pulse;
  logic                         dup_pulse;
  logic [15:0]                  drop_count;

  modport slave (
    input  in_fields, in_last, out_ready,
    output out_valid, out_msg_id, out_nfields, out_data, drop_pulse, dup_pulse, drop_count
  );

  modport master (
    output in_fields, in_last, out_ready,
    input  out_valid, out_msg_id, out_nfields, out_data, drop_pulse, dup_pulse, drop_count
  );
endinterface

// File: rtl/fast_msg_assembler.sv
// Reassembles FAST messages from decoded field words spread over lanes and cycles.
// Messages are held in a small slot ring and emitted strictly in allocation order.
module fast_msg_assembler #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned BEAT_W     = 64,
  parameter int unsigned MAX_FIELDS = 10,
  parameter int unsigned MSG_ID_W   = 21,
  parameter int unsigned NUM_SLOTS  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  fast_msg_assembler_if.slave  bus_io
);
  localparam int unsigned IDX_W   = $clog2(MAX_FIELDS);
  localparam int unsigned FIELD_W = 1 + MSG_ID_W + IDX_W + BEAT_W;
  localparam int unsigned PTR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CNT_W   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned DCNT_W  = $clog2(NUM_LANES + 1);
  localparam logic [CNT_W:0] SlotsW = (CNT_W + 1)'(NUM_SLOTS);

  typedef enum logic [1:0] {StFree, StFilling, StReady} slot_st_e;

  slot_st_e              st_q    [NUM_SLOTS];
  slot_st_e              st_d    [NUM_SLOTS];
  logic [MSG_ID_W-1:0]   id_q    [NUM_SLOTS];
  logic [MSG_ID_W-1:0]   id_d    [NUM_SLOTS];
  logic [MAX_FIELDS-1:0] mask_q  [NUM_SLOTS];
  logic [MAX_FIELDS-1:0] mask_d  [NUM_SLOTS];
  logic [BEAT_W-1:0]     data_q  [NUM_SLOTS][MAX_FIELDS];
  logic [BEAT_W-1:0]     data_d  [NUM_SLOTS][MAX_FIELDS];
  logic [IDX_W:0]        expn_q  [NUM_SLOTS];
  logic [IDX_W:0]        expn_d  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  last_q, last_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic                  drop_pulse_q, drop_pulse_d, dup_pulse_q, dup_pulse_d;

  logic                         out_valid_w;
  logic [MSG_ID_W-1:0]          out_msg_id_w;
  logic [IDX_W:0]               out_nfields_w;
  logic [MAX_FIELDS*BEAT_W-1:0] out_data_w;

  // Output view of the head slot; zero whenever nothing is being offered.
  always_comb begin
    out_valid_w   = 1'b0;
    out_msg_id_w  = '0;
    out_nfields_w = '0;
    out_data_w    = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (s == int'(head_q) && st_q[s] == StReady) begin
        out_valid_w   = 1'b1;
        out_msg_id_w  = id_q[s];
        out_nfields_w = expn_q[s];
        for (int f = 0; f < MAX_FIELDS; f++) begin
          if (f < int'(expn_q[s])) out_data_w[f*BEAT_W +: BEAT_W] = data_q[s][f];
        end
      end
    end
  end

  always_comb begin : next_state
    logic [FIELD_W-1:0]  lane_w;
    logic                lane_valid;
    logic [MSG_ID_W-1:0] lane_id;
    logic [IDX_W-1:0]    lane_idx;
    logic [BEAT_W-1:0]   lane_val;
    logic                lane_last;
    logic [CNT_W-1:0]    allocs;
    logic [DCNT_W-1:0]   n_drop;
    logic                dup;
    logic                done;
    logic                pop;
    logic [16:0]         sum;
    int                  match;
    int                  asl;
    int                  t;

    st_d       = st_q;
    id_d       = id_q;
    mask_d     = mask_q;
    data_d     = data_q;
    expn_d     = expn_q;
    last_d     = last_q;
    head_d     = head_q;
    tail_d     = tail_q;
    lane_w     = '0;
    lane_valid = 1'b0;
    lane_id    = '0;
    lane_idx   = '0;
    lane_val   = '0;
    lane_last  = 1'b0;
    allocs     = '0;
    n_drop     = '0;
    dup        = 1'b0;
    done       = 1'b0;
    match      = -1;
    asl        = 0;
    pop        = out_valid_w && bus_io.out_ready;

    for (int l = 0; l < NUM_LANES; l++) begin
      lane_w     = bus_io.in_fields[l];
      lane_valid = lane_w[FIELD_W-1];
      lane_id    = lane_w[FIELD_W-2 -: MSG_ID_W];
      lane_idx   = lane_w[BEAT_W +: IDX_W];
      lane_val   = lane_w[BEAT_W-1:0];
      lane_last  = bus_io.in_last[l];
      match      = -1;
      if (lane_valid) begin
        if (int'(lane_idx) >= MAX_FIELDS) begin
          n_drop = n_drop + DCNT_W'(1);
        end else begin
          for (int s = 0; s < NUM_SLOTS; s++) begin
            if (match < 0 && st_d[s] != StFree && id_d[s] == lane_id) match = s;
          end
          // Capacity is judged on the pre-pop count; a slot freed now is usable next cycle.
          if (match < 0) begin
            if (({1'b0, count_q} + {1'b0, allocs}) < SlotsW) begin
              asl = int'(tail_q) + int'(allocs);
              if (asl >= int'(NUM_SLOTS)) asl = asl - int'(NUM_SLOTS);
              for (int s = 0; s < NUM_SLOTS; s++) begin
                if (s == asl) begin
                  st_d[s]   = StFilling;
                  id_d[s]   = lane_id;
                  mask_d[s] = '0;
                  last_d[s] = 1'b0;
                  expn_d[s] = '0;
                  for (int f = 0; f < MAX_FIELDS; f++) data_d[s][f] = '0;
                end
              end
              match  = asl;
              allocs = allocs + CNT_W'(1);
            end else begin
              n_drop = n_drop + DCNT_W'(1);
            end
          end
          for (int s = 0; s < NUM_SLOTS; s++) begin
            if (s == match) begin
              if (st_d[s] == StReady) begin
                dup = 1'b1;
              end else begin
                for (int f = 0; f < MAX_FIELDS; f++) begin
                  if (f == int'(lane_idx)) begin
                    if (mask_d[s][f]) dup = 1'b1;
                    mask_d[s][f] = 1'b1;
                    data_d[s][f] = lane_val;
                  end
                end
                if (lane_last) begin
                  if (!last_d[s]) begin
                    last_d[s] = 1'b1;
                    expn_d[s] = {1'b0, lane_idx} + (IDX_W + 1)'(1);
                  end else if (expn_d[s] != {1'b0, lane_idx} + (IDX_W + 1)'(1)) begin
                    dup = 1'b1;
                  end
                end
              end
            end
          end
        end
      end
    end

    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (st_d[s] == StFilling && last_d[s]) begin
        done = 1'b1;
        for (int f = 0; f < MAX_FIELDS; f++) begin
          if (f < int'(expn_d[s]) && !mask_d[s][f]) done = 1'b0;
        end
        if (done) st_d[s] = StReady;
      end
    end

    if (pop) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (s == int'(head_q)) begin
          st_d[s]   = StFree;
          id_d[s]   = '0;
          mask_d[s] = '0;
          last_d[s] = 1'b0;
          expn_d[s] = '0;
          for (int f = 0; f < MAX_FIELDS; f++) data_d[s][f] = '0;
        end
      end
      head_d = (int'(head_q) == int'(NUM_SLOTS) - 1) ? '0 : head_q + PTR_W'(1);
    end

    t = int'(tail_q) + int'(allocs);
    if (t >= int'(NUM_SLOTS)) t = t - int'(NUM_SLOTS);
    tail_d  = PTR_W'(t);
    count_d = count_q + allocs - CNT_W'(pop);

    sum          = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = sum[16] ? 16'hFFFF : sum[15:0];
    drop_pulse_d = (n_drop != '0);
    dup_pulse_d  = dup;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q         <= '{default: StFree};
      id_q         <= '{default: '0};
      mask_q       <= '{default: '0};
      data_q       <= '{default: '{default: '0}};
      expn_q       <= '{default: '0};
      last_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
      dup_pulse_q  <= 1'b0;
    end else begin
      st_q         <= st_d;
      id_q         <= id_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      expn_q       <= expn_d;
      last_q       <= last_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      drop_pulse_q <= drop_pulse_d;
      dup_pulse_q  <= dup_pulse_d;
    end
  end

  assign bus_io.out_valid   = out_valid_w;
  assign bus_io.out_msg_id  = out_msg_id_w;
  assign bus_io.out_nfields = out_nfields_w;
  assign bus_io.out_data    = out_data_w;
  assign bus_io.drop_pulse  = drop_pulse_q;
  assign bus_io.dup_pulse   = dup_pulse_q;
  assign bus_io.drop_count  = drop_count_q;
endmodule

// File: tb/tb_fast_msg_assembler.sv
// Directed bench for fast_msg_assembler: hand-computed expectations per scenario.
module tb_fast_msg_assembler;
  localparam int unsigned NUM_LANES  = 8;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned MAX_FIELDS = 10;
  localparam int unsigned MSG_ID_W   = 21;
  localparam int unsigned NUM_SLOTS  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fast_msg_assembler_if #(
    .NUM_LANES (NUM_LANES),
    .BEAT_W    (BEAT_W),
    .MAX_FIELDS(MAX_FIELDS),
    .MSG_ID_W  (MSG_ID_W)
  ) bus ();

  fast_msg_assembler #(
    .NUM_LANES (NUM_LANES),
    .BEAT_W    (BEAT_W),
    .MAX_FIELDS(MAX_FIELDS),
    .MSG_ID_W  (MSG_ID_W),
    .NUM_SLOTS (NUM_SLOTS)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus_io(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [MAX_FIELDS*BEAT_W-1:0] exp_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < NUM_LANES; l++) bus.in_fields[l] = '0;
    bus.in_last = '0;
  endtask

  task automatic set_lane(input int l, input logic [20:0] id, input logic [3:0] idx,
                          input logic [63:0] val, input logic last);
    bus.in_fields[l] = {1'b1, id, idx, val};
    bus.in_last[l]   = last;
  endtask

  task automatic test_reset();
    clear_lanes();
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_msg_id !== 21'd0) begin n_err++; $display("FAIL rst_id: got %0h want 0", bus.out_msg_id); end
    n_cmp++; if (bus.out_nfields !== 5'd0) begin n_err++; $display("FAIL rst_nf: got %0d want 0", bus.out_nfields); end
    n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_data: got %0h want 0", bus.out_data); end
    n_cmp++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL rst_dropcnt: got %0d want 0", bus.drop_count); end
    n_cmp++; if ({bus.drop_pulse, bus.dup_pulse} !== 2'b00) begin n_err++; $display("FAIL rst_pulses: got %b want 00", {bus.drop_pulse, bus.dup_pulse}); end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b0;
    set_lane(0, 21'h1A5, 4'd0, 64'h1111_0000_0000_0000, 1'b0);
    set_lane(1, 21'h1A5, 4'd1, 64'h2222_0000_0000_0001, 1'b0);
    set_lane(2, 21'h1A5, 4'd2, 64'h3333_0000_0000_0002, 1'b1);
    // Invalid lane carrying a last flag must be ignored.
    bus.in_fields[5] = {1'b0, 21'h1A5, 4'd7, 64'hDEAD};
    bus.in_last[5]   = 1'b1;
    tick();
    clear_lanes();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'h1111_0000_0000_0000;
    exp_data[1*64 +: 64] = 64'h2222_0000_0000_0001;
    exp_data[2*64 +: 64] = 64'h3333_0000_0000_0002;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_msg_id !== 21'h1A5) begin n_err++; $display("FAIL basic_id: got %0h want 1a5", bus.out_msg_id); end
    n_cmp++; if (bus.out_nfields !== 5'd3) begin n_err++; $display("FAIL basic_nf: got %0d want 3", bus.out_nfields); end
    n_cmp++; if (bus.out_data !== exp_data) begin n_err++; $display("FAIL basic_data: got %0h want %0h", bus.out_data, exp_data); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_late_field();
    bus.out_ready = 1'b0;
    set_lane(0, 21'd7, 4'd1, 64'hAAAA, 1'b1);
    tick();
    clear_lanes();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL late_c1: got %0b want 0", bus.out_valid); end
    tick();
    tick();
    set_lane(0, 21'd7, 4'd0, 64'hBBBB, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL late_c3: got %0b want 0", bus.out_valid); end
    tick();
    clear_lanes();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'hBBBB;
    exp_data[1*64 +: 64] = 64'hAAAA;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL late_c4: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_nfields !== 5'd2) begin n_err++; $display("FAIL late_nf: got %0d want 2", bus.out_nfields); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_msg_id !== 21'd7 || bus.out_data !== exp_data) begin
        n_err++;
        $display("FAIL late_hold%0d: got v=%0b id=%0h data=%0h want v=1 id=7 data=%0h",
                 i, bus.out_valid, bus.out_msg_id, bus.out_data, exp_data);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL late_pop: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    set_lane(0, 21'h10, 4'd0, 64'd1, 1'b0);
    set_lane(1, 21'h11, 4'd0, 64'd2, 1'b0);
    set_lane(2, 21'h12, 4'd0, 64'd3, 1'b0);
    tick();
    clear_lanes();
    n_cmp++; if (bus.drop_pulse !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %0b want 1", bus.drop_pulse); end
    n_cmp++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_cnt: got %0d want 1", bus.drop_count); end
    n_cmp++; if (bus.dup_pulse !== 1'b0) begin n_err++; $display("FAIL ovf_dup: got %0b want 0", bus.dup_pulse); end
    set_lane(0, 21'h10, 4'd1, 64'd4, 1'b1);
    set_lane(1, 21'h11, 4'd1, 64'd5, 1'b1);
    set_lane(2, 21'h12, 4'd0, 64'd6, 1'b1);
    tick();
    clear_lanes();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'd1;
    exp_data[1*64 +: 64] = 64'd4;
    n_cmp++; if (bus.drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_cnt2: got %0d want 2", bus.drop_count); end
    n_cmp++; if (bus.out_msg_id !== 21'h10 || bus.out_data !== exp_data) begin n_err++; $display("FAIL ovf_first: got id=%0h data=%0h want id=10 data=%0h", bus.out_msg_id, bus.out_data, exp_data); end
    bus.out_ready = 1'b1;
    tick();
    exp_data[0*64 +: 64] = 64'd2;
    exp_data[1*64 +: 64] = 64'd5;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_msg_id !== 21'h11 || bus.out_data !== exp_data) begin n_err++; $display("FAIL ovf_second: got v=%0b id=%0h data=%0h want v=1 id=11 data=%0h", bus.out_valid, bus.out_msg_id, bus.out_data, exp_data); end
    n_cmp++; if (bus.drop_pulse !== 1'b0) begin n_err++; $display("FAIL ovf_pulse_clr: got %0b want 0", bus.drop_pulse); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_dup();
    bus.out_ready = 1'b0;
    set_lane(0, 21'd9, 4'd0, 64'd5, 1'b0);
    set_lane(1, 21'd9, 4'd0, 64'd6, 1'b0);
    set_lane(2, 21'd9, 4'd12, 64'hFF, 1'b0);
    set_lane(3, 21'd9, 4'd1, 64'd7, 1'b1);
    tick();
    clear_lanes();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'd6;
    exp_data[1*64 +: 64] = 64'd7;
    n_cmp++; if (bus.dup_pulse !== 1'b1) begin n_err++; $display("FAIL dup_pulse: got %0b want 1", bus.dup_pulse); end
    n_cmp++; if (bus.drop_pulse !== 1'b1) begin n_err++; $display("FAIL dup_idxdrop: got %0b want 1", bus.drop_pulse); end
    n_cmp++; if (bus.drop_count !== 16'd3) begin n_err++; $display("FAIL dup_cnt: got %0d want 3", bus.drop_count); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_nfields !== 5'd2 || bus.out_data !== exp_data) begin n_err++; $display("FAIL dup_data: got v=%0b nf=%0d data=%0h want v=1 nf=2 data=%0h", bus.out_valid, bus.out_nfields, bus.out_data, exp_data); end
    set_lane(0, 21'd9, 4'd0, 64'h99, 1'b0);
    tick();
    clear_lanes();
    n_cmp++; if (bus.dup_pulse !== 1'b1 || bus.drop_pulse !== 1'b0) begin n_err++; $display("FAIL dup_ready: got dup=%0b drop=%0b want dup=1 drop=0", bus.dup_pulse, bus.drop_pulse); end
    n_cmp++; if (bus.out_data !== exp_data) begin n_err++; $display("FAIL dup_keep: got %0h want %0h", bus.out_data, exp_data); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.dup_pulse !== 1'b0) begin n_err++; $display("FAIL dup_pop: got v=%0b dup=%0b want 0 0", bus.out_valid, bus.dup_pulse); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    set_lane(0, 21'h100, 4'd0, 64'hA0, 1'b1);
    set_lane(1, 21'h200, 4'd0, 64'hB0, 1'b0);
    tick();
    clear_lanes();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_msg_id !== 21'h100) begin n_err++; $display("FAIL b2b_a: got v=%0b id=%0h want v=1 id=100", bus.out_valid, bus.out_msg_id); end
    tick();
    set_lane(0, 21'h200, 4'd1, 64'hB1, 1'b1);
    tick();
    clear_lanes();
    n_cmp++; if (bus.out_msg_id !== 21'h100 || bus.out_nfields !== 5'd1) begin n_err++; $display("FAIL b2b_hol: got id=%0h nf=%0d want id=100 nf=1", bus.out_msg_id, bus.out_nfields); end
    // Pop of A and a new ID in the same cycle: the ring is still full, so it drops.
    set_lane(0, 21'h300, 4'd0, 64'hC0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'hB0;
    exp_data[1*64 +: 64] = 64'hB1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_msg_id !== 21'h200 || bus.out_data !== exp_data) begin n_err++; $display("FAIL b2b_b: got v=%0b id=%0h data=%0h want v=1 id=200 data=%0h", bus.out_valid, bus.out_msg_id, bus.out_data, exp_data); end
    n_cmp++; if (bus.drop_pulse !== 1'b1 || bus.drop_count !== 16'd4) begin n_err++; $display("FAIL b2b_popalloc: got pulse=%0b cnt=%0d want 1 4", bus.drop_pulse, bus.drop_count); end
    tick();
    clear_lanes();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_msg_id !== 21'h300 || bus.out_nfields !== 5'd1) begin n_err++; $display("FAIL b2b_c: got v=%0b id=%0h nf=%0d want 1 300 1", bus.out_valid, bus.out_msg_id, bus.out_nfields); end
    n_cmp++; if (bus.out_data !== {{(MAX_FIELDS-1)*BEAT_W{1'b0}}, 64'hC0}) begin n_err++; $display("FAIL b2b_cdata: got %0h want c0", bus.out_data); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.drop_count !== 16'd4) begin n_err++; $display("FAIL b2b_end: got v=%0b cnt=%0d want 0 4", bus.out_valid, bus.drop_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    set_lane(0, 21'd3, 4'd0, 64'h30, 1'b0);
    set_lane(1, 21'd3, 4'd1, 64'h31, 1'b0);
    tick();
    clear_lanes();
    rstn = 1'b0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_msg_id !== 21'd0 || bus.out_nfields !== 5'd0 || bus.out_data !== '0) begin n_err++; $display("FAIL rmid_out: got v=%0b id=%0h nf=%0d want all 0", bus.out_valid, bus.out_msg_id, bus.out_nfields); end
    n_cmp++; if (bus.drop_count !== 16'd0 || bus.drop_pulse !== 1'b0 || bus.dup_pulse !== 1'b0) begin n_err++; $display("FAIL rmid_cnt: got cnt=%0d drop=%0b dup=%0b want 0 0 0", bus.drop_count, bus.drop_pulse, bus.dup_pulse); end
    rstn = 1'b1;
    set_lane(0, 21'd3, 4'd2, 64'h32, 1'b0);
    set_lane(1, 21'd3, 4'd3, 64'h33, 1'b1);
    tick();
    clear_lanes();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_partial: got %0b want 0", bus.out_valid); end
    set_lane(0, 21'd3, 4'd0, 64'h40, 1'b0);
    set_lane(1, 21'd3, 4'd1, 64'h41, 1'b0);
    tick();
    clear_lanes();
    exp_data = '0;
    exp_data[0*64 +: 64] = 64'h40;
    exp_data[1*64 +: 64] = 64'h41;
    exp_data[2*64 +: 64] = 64'h32;
    exp_data[3*64 +: 64] = 64'h33;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_nfields !== 5'd4 || bus.out_data !== exp_data) begin n_err++; $display("FAIL rmid_fresh: got v=%0b nf=%0d data=%0h want v=1 nf=4 data=%0h", bus.out_valid, bus.out_nfields, bus.out_data, exp_data); end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_pop: got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    clear_lanes();
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_late_field();
    test_overflow();
    test_dup();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
